// File: rtl/operand_fetch.sv
// Operand fetch: scoreboard hazard check, operand resolution and output register.
// Optional OPERAND_FETCH_BYPASS_EN forwards same-cycle writeback data.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_read_address_0,
  input  logic [31:0] rf_read_data_0,
  output logic [4:0]  rf_read_address_1,
  input  logic [31:0] rf_read_data_1,
  input  logic        wb_valid,
  input  logic [4:0]  wb_address,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rd
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:1] pending;
  logic [31:0] pend_vec;
  logic [31:0] pend_next;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, rd_wr;
  logic        pend1, pend2;
  logic        fwd1, fwd2;
  logic        hazard;
  logic        accept;
  logic [31:0] op1, op2;

  assign opcode = in_instr[6:0];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];

  assign rf_read_address_0 = rs1;
  assign rf_read_address_1 = rs2;

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC ||
                      opcode == OP_JAL);
  assign rs2_used = opcode == OP_OP || opcode == OP_STORE ||
                    opcode == OP_BRANCH;
  assign rd_wr    = !(opcode == OP_STORE || opcode == OP_BRANCH) &&
                    rd != 5'd0;

  // Bit 0 is hardwired clear so x0 is never pending.
  assign pend_vec = {pending, 1'b0};
  assign pend1    = pend_vec[rs1];
  assign pend2    = pend_vec[rs2];

`ifdef OPERAND_FETCH_BYPASS_EN
  assign fwd1 = pend1 && wb_valid && wb_address == rs1;
  assign fwd2 = pend2 && wb_valid && wb_address == rs2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign hazard = in_valid &&
                  ((rs1_used && pend1 && !fwd1) ||
                   (rs2_used && pend2 && !fwd2));

  assign in_ready = !reset && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1 = 32'd0;
    op2 = 32'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (rs1_used) op1 = fwd1 ? wb_data : rf_read_data_0;
    if (rs2_used) op2 = fwd2 ? wb_data : rf_read_data_1;
`else
    if (rs1_used) op1 = rf_read_data_0;
    if (rs2_used) op2 = rf_read_data_1;
`endif
  end

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    pend_next = pend_vec;
    if (wb_valid) pend_next[wb_address] = 1'b0;
    if (accept && rd_wr) pend_next[rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
    end else begin
      pending <= pend_next[31:1];
      if (accept) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_instr    <= in_instr;
        out_rs1_data <= op1;
        out_rs2_data <= op2;
        out_rd       <= rd_wr ? rd : 5'd0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch with a behavioural register file.
// Works with and without OPERAND_FETCH_BYPASS_EN.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_read_address_0;
  logic [31:0] rf_read_data_0;
  logic [4:0]  rf_read_address_1;
  logic [31:0] rf_read_data_1;
  logic        wb_valid;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;

  logic [31:0] regs [32];
  logic        rf_init;
  int          n_checks = 0;
  int          n_fail = 0;

  operand_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .rf_read_address_0 (rf_read_address_0),
    .rf_read_data_0    (rf_read_data_0),
    .rf_read_address_1 (rf_read_address_1),
    .rf_read_data_1    (rf_read_data_1),
    .wb_valid          (wb_valid),
    .wb_address        (wb_address),
    .wb_data           (wb_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_instr         (out_instr),
    .out_rs1_data      (out_rs1_data),
    .out_rs2_data      (out_rs2_data),
    .out_rd            (out_rd)
  );

  always #5 clk = ~clk;

  assign rf_read_data_0 = (rf_read_address_0 == 5'd0) ? 32'd0 :
                          regs[rf_read_address_0];
  assign rf_read_data_1 = (rf_read_address_1 == 5'd0) ? 32'd0 :
                          regs[rf_read_address_1];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[2]  <= 32'h22;
      regs[5]  <= 32'hAAAA;
      regs[6]  <= 32'h66;
      regs[12] <= 32'hC;
    end else if (wb_valid && wb_address != 5'd0) begin
      regs[wb_address] <= wb_data;
    end
  end

  function automatic logic [31:0] i_type(input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] s_type(input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pend();
    return {dut.pending, 1'b0};
  endfunction

  initial begin
    reset      = 1'b1;
    rf_init    = 1'b1;
    in_valid   = 1'b0;
    in_instr   = 32'd0;
    in_pc      = 32'd0;
    wb_valid   = 1'b0;
    wb_address = 5'd0;
    wb_data    = 32'd0;
    out_ready  = 1'b1;
    tick();
    tick();
    rf_init = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rs1", out_rs1_data, 32'd0);
    check("rst_pending", pend(), 32'd0);

    // Independent issue
    reset    = 1'b0;
    in_valid = 1'b1;
    in_instr = i_type(5'd1, 5'd0, 12'd5);
    in_pc    = 32'h100;
    #1;
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("issue_valid", {31'd0, out_valid}, 32'd1);
    check("issue_rd", {27'd0, out_rd}, 32'd1);
    check("issue_rs1", out_rs1_data, 32'd0);
    check("issue_rs2_unused", out_rs2_data, 32'd0);
    check("issue_pc", out_pc, 32'h100);
    check("issue_pending", pend(), 32'h2);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // RAW stall on x3
    in_valid = 1'b1;
    in_instr = i_type(5'd3, 5'd0, 12'd7);
    in_pc    = 32'h104;
    tick();
    in_instr = r_type(5'd4, 5'd3, 5'd2);
    in_pc    = 32'h108;
    #1;
    check("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    check("raw_stall1", {31'd0, in_ready}, 32'd0);
    wb_valid   = 1'b1;
    wb_address = 5'd3;
    wb_data    = 32'h1234;
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    check("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
`else
    check("raw_wb_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("raw_after_wb", {31'd0, in_ready}, 32'd1);
    tick();
`endif
    in_valid = 1'b0;
    check("raw_valid", {31'd0, out_valid}, 32'd1);
    check("raw_rs1", out_rs1_data, 32'h1234);
    check("raw_rs2", out_rs2_data, 32'h22);
    check("raw_rd", {27'd0, out_rd}, 32'd4);
    check("raw_pending", pend(), 32'h12);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = i_type(5'd8, 5'd0, 12'd1);
    in_pc     = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h108);
      check("bp_rs1", out_rs1_data, 32'h1234);
      tick();
    end
    check("bp_pending", pend(), 32'h12);
    out_ready = 1'b1;
    #1;
    check("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_rd", {27'd0, out_rd}, 32'd8);
    check("bp_next_pending", pend(), 32'h112);

    // Same-cycle set and clear on x5
    in_valid   = 1'b1;
    in_instr   = i_type(5'd5, 5'd0, 12'd3);
    in_pc      = 32'h110;
    wb_valid   = 1'b1;
    wb_address = 5'd5;
    wb_data    = 32'd9;
    tick();
    in_valid = 1'b0;
    check("setclr_pending", pend(), 32'h132);
    wb_address = 5'd1;
    wb_data    = 32'h11;
    tick();
    wb_valid = 1'b0;
    check("wb_clear", pend(), 32'h130);

    // Store with pending base, then x0 destination
    in_valid = 1'b1;
    in_instr = i_type(5'd7, 5'd0, 12'd2);
    in_pc    = 32'h114;
    tick();
    in_instr = s_type(5'd7, 5'd6);
    in_pc    = 32'h118;
    #1;
    check("st_stall", {31'd0, in_ready}, 32'd0);
    in_valid   = 1'b0;
    wb_valid   = 1'b1;
    wb_address = 5'd7;
    wb_data    = 32'h70;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1;
    #1;
    check("st_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("st_rd", {27'd0, out_rd}, 32'd0);
    check("st_rs1", out_rs1_data, 32'h70);
    check("st_rs2", out_rs2_data, 32'h66);
    check("st_pending", pend(), 32'h130);
    in_instr = i_type(5'd0, 5'd0, 12'd1);
    in_pc    = 32'h11C;
    tick();
    check("x0_rd", {27'd0, out_rd}, 32'd0);
    check("x0_pending", pend(), 32'h130);

    // LUI ignores its pending rs1 field
    in_instr = {12'h000, 5'd5, 3'b000, 5'd9, 7'b0110111};
    in_pc    = 32'h120;
    #1;
    check("lui_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("lui_rs1", out_rs1_data, 32'd0);
    check("lui_pending", pend(), 32'h330);

    // Reset during a stall
    in_instr = r_type(5'd10, 5'd5, 5'd0);
    in_pc    = 32'h124;
    #1;
    check("rs_stall", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rs_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    check("rs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_pending", pend(), 32'd0);
    check("rs_rd", {27'd0, out_rd}, 32'd0);
    #1;
    check("rs_accept", {31'd0, in_ready}, 32'd1);
    tick();
    check("rs_out_valid", {31'd0, out_valid}, 32'd1);
    check("rs_out_rd", {27'd0, out_rd}, 32'd10);
    check("rs_out_rs1", out_rs1_data, 32'd9);
    check("rs_out_pending", pend(), 32'h400);

    // Source equal to destination reads the old value
    in_instr = i_type(5'd12, 5'd12, 12'd1);
    in_pc    = 32'h128;
    #1;
    check("self_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("self_rs1", out_rs1_data, 32'hC);
    check("self_pending", pend(), 32'h1400);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
